usb_tx_serializer: RTL
======================

# usb_tx_serializer

Downstream neighbour of the four-channel programmer combiner. Takes each wide frame the combiner releases on its tx port (`tx_data`/`tx_enable`) and reports readiness back as the combiner's `tx_empty`. Streams each frame byte-by-byte into the USB bridge's 8-bit synchronous write FIFO (FT245-sync style: write occurs on an edge where WR# and TXE# are both low). Holds one frame at a time, with back-pressure in both directions.

## Interface
- WORD_W, 801: frame width in bits; NBYTES = ceil(WORD_W/8) = 101 at default.
- CNT_W, 16: width of frames_sent counter.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- word_data  in  WORD_W  frame from combiner (connects to tx_data).
- word_valid  in  1  frame present; sampled only while word_ready=1 (connects to tx_enable).
- word_ready  out  1  block idle and able to accept a frame (connects to tx_empty).
- usb_data  out  8  byte to USB FIFO.
- usb_wr_n  out  1  active-low write strobe.
- usb_txe_n  in  1  active-low: USB FIFO has space.
- busy  out  1  frame in progress.
- frames_sent  out  CNT_W  count of fully transmitted frames, wraps.

## Operation
- Reset values: word_ready=1, usb_wr_n=1, usb_data=0x00, busy=0, frames_sent=0, byte index=0, state=IDLE.
- States: IDLE -> SEND -> (CSUM if USB_TX_CHECKSUM_EN) -> IDLE.
- IDLE: word_ready=1. On an edge with word_valid=1: latch word_data into the shift register, set byte index=0, set usb_data=word_data[7:0], usb_wr_n=0, busy=1, word_ready=0, go to SEND.
- SEND: a byte transfers on an edge where usb_wr_n=0 and usb_txe_n=0.
  - On transfer of a byte other than the last: present the next byte and keep usb_wr_n=0.
  - If usb_txe_n=1: hold usb_data and usb_wr_n unchanged, with no index advance (stall of any length).
- Byte order: LSB first. Byte k = word bits [8k+7:8k]. The last byte is zero-padded above bit WORD_W-1. At default, byte 100 = {7'b0, word[800]}.
- On transfer of the last data byte (index NBYTES-1):
  - without checksum: usb_wr_n=1, busy=0, word_ready=1, frames_sent+1, go to IDLE.
  - with checksum: go to CSUM.
- word_valid is ignored outside IDLE. The combiner must hold its frame until it sees word_ready=1.
- frames_sent wraps from 2^CNT_W-1 to 0.

## Timing
- Accept-to-first-byte: frame accepted at edge N; usb_wr_n=0 with byte 0 valid after edge N.
- Byte 0 can transfer at edge N+1.
- Unstalled frame: NBYTES edges from first strobe to the last transfer (NBYTES+1 with checksum).
- word_ready returns to 1 the cycle after the final transfer. The earliest next accept is that cycle's edge, giving one idle (wr_n=1) cycle between frames.
- usb_txe_n is sampled only on edges where usb_wr_n=0. TXE# toggling while idle has no effect.
- Reset asserted mid-frame:
  - usb_wr_n=1 and outputs go to their reset values immediately (asynchronously).
  - The partial frame is discarded and never resumed; frames_sent is not incremented.
- Reset release: the first accept is possible at the first edge after deassertion.

## Configuration
- USB_TX_CHECKSUM_EN defined:
  - After the last data byte, a CSUM state sends one extra byte, the XOR of all NBYTES data bytes (including padding), with the same TXE# stall rules.
  - frames_sent increments and word_ready rises on the checksum transfer.
- Undefined: no CSUM state; frames are exactly NBYTES bytes.

## Test plan
- Reset with usb_txe_n=0 and word_valid=0 -> word_ready=1, usb_wr_n=1, usb_data=0x00, busy=0, frames_sent=0; no strobes over 20 cycles.
- word_data = {1'b1, 792'b0, 8'hA5}, valid 1 cycle, usb_txe_n=0 -> bytes 0xA5, 99×0x00, 0x01 on consecutive edges; word_ready high the next cycle; frames_sent=1.
  - With the macro defined: checksum byte 0xA4 follows.
- Same frame with usb_txe_n forced high for 5 cycles after byte 3 -> byte 4 held stable with wr_n=0 for all 5 cycles; no byte lost or duplicated; 101 total transfers.
- word_valid held high continuously with incrementing data -> frames separated by exactly one wr_n=1 cycle; word_valid ignored while busy; each frame's byte 0 matches its data.
- Reset pulsed after byte 50 -> wr_n=1 the same cycle; frames_sent unchanged; the next frame starts at byte 0 with its own data.
- Preload frames_sent to 16'hFFFF via 65535 short-WORD_W (8) frames -> the next frame completes with frames_sent=0.

Source files
------------

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - wide-frame to byte-stream serializer for an FT245-sync USB write FIFO
//
// Accepts one WORD_W-bit frame at a time from the upstream combiner and streams it
// LSB byte first into the USB FIFO, honouring TXE# back-pressure on every byte.
// Optional feature macro: USB_TX_CHECKSUM_EN appends one XOR checksum byte per frame.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   asynchronous active-high reset
//   word_data    in   frame from combiner (its tx_data)
//   word_valid   in   frame present, sampled only while word_ready=1 (its tx_enable)
//   word_ready   out  idle and able to accept a frame (its tx_empty)
//   usb_data     out  byte presented to the USB FIFO
//   usb_wr_n     out  active-low write strobe
//   usb_txe_n    in   active-low: USB FIFO has space
//   busy         out  frame in progress
//   frames_sent  out  count of fully transmitted frames, wraps

module usb_tx_serializer #(
   parameter int WORD_W = 801,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [7:0]        usb_data,
   output logic              usb_wr_n,
   input  logic              usb_txe_n,
   output logic              busy,
   output logic [CNT_W-1:0]  frames_sent
);

   localparam int NBYTES = (WORD_W + 7) / 8;
   localparam int PAD_W  = NBYTES * 8;
   localparam int IDX_W  = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;

   state_t             r_state;
   logic [PAD_W-1:0]   r_shift;   // bytes not yet presented, next one in [7:0]
   logic [IDX_W-1:0]   r_idx;     // index of the byte currently on usb_data
   logic               r_ready;
   logic               r_wr_n;
   logic [7:0]         r_data;
   logic               r_busy;
   logic [CNT_W-1:0]   r_frames;
`ifdef USB_TX_CHECKSUM_EN
   logic [7:0]         r_csum;    // XOR of bytes already transferred
`endif

   logic [PAD_W-1:0]   w_padded;
   logic               w_xfer;
   logic               w_last;

   // Zero-extend so the final partial byte is padded with zeros.
   assign w_padded = PAD_W'(word_data);
   // FT245-sync: a byte moves on an edge where WR# and TXE# are both low.
   assign w_xfer   = !r_wr_n && !usb_txe_n;
   assign w_last   = (r_idx == IDX_W'(NBYTES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_idx    <= '0;
         r_ready  <= 1'b1;
         r_wr_n   <= 1'b1;
         r_data   <= 8'h00;
         r_busy   <= 1'b0;
         r_frames <= '0;
`ifdef USB_TX_CHECKSUM_EN
         r_csum   <= 8'h00;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (word_valid) begin
                  r_shift <= w_padded >> 8;
                  r_idx   <= '0;
                  r_data  <= w_padded[7:0];
                  r_wr_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= S_SEND;
`ifdef USB_TX_CHECKSUM_EN
                  r_csum  <= 8'h00;
`endif
               end
            end
            S_SEND: begin
               // Without a transfer everything holds: that is the TXE# stall.
               if (w_xfer) begin
`ifdef USB_TX_CHECKSUM_EN
                  r_csum <= r_csum ^ r_data;
`endif
                  if (w_last) begin
`ifdef USB_TX_CHECKSUM_EN
                     r_data  <= r_csum ^ r_data;
                     r_state <= S_CSUM;
`else
                     r_wr_n   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_ready  <= 1'b1;
                     r_frames <= r_frames + 1'b1;
                     r_state  <= S_IDLE;
`endif
                  end else begin
                     r_data  <= r_shift[7:0];
                     r_shift <= r_shift >> 8;
                     r_idx   <= r_idx + 1'b1;
                  end
               end
            end
            S_CSUM: begin
               if (w_xfer) begin
                  r_wr_n   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_ready  <= 1'b1;
                  r_frames <= r_frames + 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign word_ready  = r_ready;
   assign usb_wr_n    = r_wr_n;
   assign usb_data    = r_data;
   assign busy        = r_busy;
   assign frames_sent = r_frames;

endmodule
